// File: rtl/apb_image_pkg.sv
// apb_image_pkg: shared constants and types for the APB image register file.
//   - Register map addresses (CTRL, white pixel, Np, Nw, parameter block, pixel base).
//   - CTRL bit indices.
//   - Control FSM state enum and the debug struct exposed by the top.
package apb_image_pkg;

    localparam int CTRL_ADDR  = 0;
    localparam int WHITE_ADDR = 1;
    localparam int NP_ADDR    = 2;
    localparam int NW_ADDR    = 3;
    localparam int PARAM_BASE = 4;
    localparam int PIX_BASE   = 10;

    localparam int CTRL_RUN_BIT = 0;
    localparam int CTRL_ERR_BIT = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } state_e;

    // Observability bundle: FSM state plus the two live CTRL bits.
    typedef struct packed {
        state_e state;
        logic   cfg_err;
        logic   run;
    } regfile_dbg_t;

endpackage

// File: rtl/apb_image_regfile_if.sv
// apb_image_regfile_if: APB write/read bus between the stimulus (master) and
// the image register file (slave).
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA : master -> slave
//   PRDATA, PREADY, PSLVERR              : slave -> master
// Handshake: an access happens on every rising clk edge where PSEL && PENABLE
// are high; PREADY is always 1 so every access completes in that cycle, and
// PSLVERR is only meaningful while PSEL && PENABLE are high.
interface apb_image_regfile_if #(
    parameter int Amba_Addr_Depth = 10,
    parameter int Amba_Word       = 16
);
    logic                       PSEL;
    logic                       PENABLE;
    logic                       PWRITE;
    logic [Amba_Addr_Depth-1:0] PADDR;
    logic [Amba_Word-1:0]       PWDATA;
    logic [Amba_Word-1:0]       PRDATA;
    logic                       PREADY;
    logic                       PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/image_mem.sv
// image_mem: pixel storage for primary + watermark images.
//   clk, rst        : clock, async active-low reset (clears rdata only)
//   we/waddr/wdata  : APB write port
//   raddr/rdata     : core read port, one cycle latency, read-before-write
//   rb_addr/rb_data : combinational readback port (only with APB_READBACK_EN)
// The array itself is never reset.
module image_mem #(
    parameter int Addr_W = 10,
    parameter int Data_W = 8,
    parameter int Depth  = 1014
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [Addr_W-1:0] waddr,
    input  logic [Data_W-1:0] wdata,
    input  logic [Addr_W-1:0] raddr,
    output logic [Data_W-1:0] rdata
`ifdef APB_READBACK_EN
    ,
    input  logic [Addr_W-1:0] rb_addr,
    output logic [Data_W-1:0] rb_data
`endif
);

    logic [Data_W-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Nonblocking write above means a same-index read here sees the old word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else begin
            rdata <= (raddr < Addr_W'(Depth)) ? mem[raddr] : '0;
        end
    end

`ifdef APB_READBACK_EN
    assign rb_data = (rb_addr < Addr_W'(Depth)) ? mem[rb_addr] : '0;
`endif

endmodule

// File: rtl/apb_image_regfile.sv
// apb_image_regfile: APB slave holding CTRL, configuration registers and pixel
// storage for the watermark core; launches the core and tracks its completion.
//   clk, rst    : clock, async active-low reset
//   apb         : APB slave port (PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA/PREADY/PSLVERR)
//   start       : one-cycle core launch pulse (LAUNCH state)
//   busy        : high in LAUNCH and RUN
//   white_pix, np, nw, params : configuration registers 1, 2, 3 and 4..9
//   mem_raddr/mem_rdata : core pixel read port (index 0 = APB address 10)
//   Image_Done  : core completion pulse; done_irq : one-cycle completion pulse
//   dbg         : FSM state and CTRL bits
// Optional feature macro: APB_READBACK_EN enables APB reads through PRDATA.
module apb_image_regfile
    import apb_image_pkg::*;
#(
    parameter int Amba_Addr_Depth = 10,
    parameter int Amba_Word       = 16,
    parameter int Data_Depth      = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    apb_image_regfile_if.slave         apb,
    output logic                       start,
    output logic                       busy,
    output logic [Amba_Word-1:0]       white_pix,
    output logic [Amba_Word-1:0]       np,
    output logic [Amba_Word-1:0]       nw,
    output logic [6*Amba_Word-1:0]     params,
    input  logic [Amba_Addr_Depth-1:0] mem_raddr,
    output logic [Data_Depth-1:0]      mem_rdata,
    input  logic                       Image_Done,
    output logic                       done_irq,
    output regfile_dbg_t               dbg
);

    localparam int MEM_DEPTH = (1 << Amba_Addr_Depth) - PIX_BASE;
    // Two extra bits over 2*Amba_Word so Np^2 + Nw^2 + 10 cannot wrap.
    localparam int VW = 2 * Amba_Word + 2;

    state_e state, state_nx;
    logic   run_q, err_q;
    logic [Amba_Word-1:0] cfg_q [1:9];

    logic access, wr_access, accept_wr, wr_ctrl, wr_pix, launch_req, cfg_ok;
    logic pslverr;
    logic [Amba_Addr_Depth-1:0] pix_idx;
    logic [VW-1:0] np_x, nw_x, need;

    assign access     = apb.PSEL && apb.PENABLE;
    assign wr_access  = access && apb.PWRITE;
    // LAUNCH is treated like RUN: the core is already committed to the config.
    assign accept_wr  = wr_access && (state == IDLE || state == DONE);
    assign wr_ctrl    = accept_wr && (apb.PADDR == Amba_Addr_Depth'(CTRL_ADDR));
    assign wr_pix     = accept_wr && (apb.PADDR >= Amba_Addr_Depth'(PIX_BASE));
    assign launch_req = wr_ctrl && apb.PWDATA[CTRL_RUN_BIT];
    assign pix_idx    = apb.PADDR - Amba_Addr_Depth'(PIX_BASE);

    assign np_x   = VW'(cfg_q[NP_ADDR]);
    assign nw_x   = VW'(cfg_q[NW_ADDR]);
    assign need   = np_x * np_x + nw_x * nw_x + VW'(PIX_BASE);
    assign cfg_ok = (np_x != '0) && (nw_x != '0) && (nw_x <= np_x) &&
                    (need <= (VW'(1) << Amba_Addr_Depth));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (launch_req && cfg_ok) state_nx = LAUNCH;
            LAUNCH:  state_nx = RUN;
            RUN:     if (Image_Done) state_nx = DONE;
            DONE:    state_nx = (launch_req && cfg_ok) ? LAUNCH : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        pslverr = 1'b0;
        if (wr_access) begin
            if (state == LAUNCH || state == RUN) begin
                pslverr = 1'b1;
            end else if (launch_req && !cfg_ok) begin
                pslverr = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            run_q <= 1'b0;
            err_q <= 1'b0;
            for (int i = 1; i <= 9; i++) begin
                cfg_q[i] <= '0;
            end
        end else begin
            state <= state_nx;
            if (state == DONE) begin
                run_q <= 1'b0;
            end
            if (wr_ctrl) begin
                if (apb.PWDATA[CTRL_RUN_BIT]) begin
                    if (cfg_ok) begin
                        run_q <= 1'b1;
                        err_q <= 1'b0;
                    end else begin
                        err_q <= 1'b1;
                    end
                end else begin
                    err_q <= 1'b0;
                end
            end
            for (int i = 1; i <= 9; i++) begin
                if (accept_wr && apb.PADDR == Amba_Addr_Depth'(i)) begin
                    cfg_q[i] <= apb.PWDATA;
                end
            end
        end
    end

    assign start    = (state == LAUNCH);
    assign busy     = (state == LAUNCH) || (state == RUN);
    assign done_irq = (state == DONE);

    assign white_pix = cfg_q[WHITE_ADDR];
    assign np        = cfg_q[NP_ADDR];
    assign nw        = cfg_q[NW_ADDR];
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            params[i*Amba_Word +: Amba_Word] = cfg_q[PARAM_BASE + i];
        end
    end

    assign dbg.state   = state;
    assign dbg.cfg_err = err_q;
    assign dbg.run     = run_q;

    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = pslverr;

`ifdef APB_READBACK_EN
    logic [Data_Depth-1:0] rb_data;
    logic [Amba_Word-1:0]  prdata;

    always_comb begin
        prdata = '0;
        if (access && !apb.PWRITE) begin
            if (apb.PADDR == Amba_Addr_Depth'(CTRL_ADDR)) begin
                prdata[CTRL_RUN_BIT] = run_q;
                prdata[CTRL_ERR_BIT] = err_q;
            end else if (apb.PADDR >= Amba_Addr_Depth'(PIX_BASE)) begin
                prdata = Amba_Word'(rb_data);
            end else begin
                for (int i = 1; i <= 9; i++) begin
                    if (apb.PADDR == Amba_Addr_Depth'(i)) prdata = cfg_q[i];
                end
            end
        end
    end
    assign apb.PRDATA = prdata;
`else
    assign apb.PRDATA = '0;
`endif

    image_mem #(
        .Addr_W (Amba_Addr_Depth),
        .Data_W (Data_Depth),
        .Depth  (MEM_DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_pix),
        .waddr (pix_idx),
        .wdata (apb.PWDATA[Data_Depth-1:0]),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
`ifdef APB_READBACK_EN
        ,
        .rb_addr (pix_idx),
        .rb_data (rb_data)
`endif
    );

endmodule
